// File: rtl/risc_toy_mem_responder.sv
// RISC-TOY memory responder: shared word array serving fetch, data and loader ports.
// Array is zero-cleared after reset; reads are registered and write-first.
module risc_toy_mem_responder #(
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IREQ,
  input  logic [29:0]   IADDR,
  output logic [31:0]   INSTR,
  input  logic          DREQ,
  input  logic          DRW,
  input  logic [29:0]   DADDR,
  input  logic [31:0]   DWDATA,
  output logic [31:0]   DRDATA,
  input  logic          LD_EN,
  input  logic [AW-1:0] LD_ADDR,
  input  logic [31:0]   LD_DATA,
  output logic          INIT_BUSY
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [31:0]   mem [DEPTH];
  state_t        state_q, state_nx;
  logic [AW-1:0] cnt_q, cnt_nx;
  logic          busy_q, busy_nx;
  logic [31:0]   instr_q, instr_nx;
  logic [31:0]   drdata_q, drdata_nx;
  logic          rdy, clr_we, ld_we, d_we;
  logic [AW-1:0] ia, da;
  logic [31:0]   i_fwd, d_fwd;
  logic          unused_addr_bits;

  assign ia     = IADDR[AW-1:0];
  assign da     = DADDR[AW-1:0];
  assign rdy    = (state_q == S_READY);
  assign clr_we = ~rdy;
  assign ld_we  = rdy & LD_EN;
  assign d_we   = rdy & DREQ & DRW;

  assign unused_addr_bits = ^{IADDR[29:AW], DADDR[29:AW]};

  // Data-port write beats the loader on a collision.
  always_comb begin
    i_fwd = mem[ia];
    if (d_we && (da == ia))
      i_fwd = DWDATA;
    else if (ld_we && (LD_ADDR == ia))
      i_fwd = LD_DATA;
    d_fwd = mem[da];
    if (ld_we && (LD_ADDR == da))
      d_fwd = LD_DATA;
  end

  always_comb begin
    state_nx  = state_q;
    cnt_nx    = cnt_q;
    busy_nx   = busy_q;
    instr_nx  = instr_q;
    drdata_nx = drdata_q;
    unique case (state_q)
      S_CLEAR: begin
        cnt_nx = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_nx = S_READY;
          busy_nx  = 1'b0;
        end
      end
      S_READY: begin
        if (IREQ)
          instr_nx = i_fwd;
        if (DREQ && !DRW)
          drdata_nx = d_fwd;
      end
      default: state_nx = S_CLEAR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_CLEAR;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
      instr_q  <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_nx;
      cnt_q    <= cnt_nx;
      busy_q   <= busy_nx;
      instr_q  <= instr_nx;
      drdata_q <= drdata_nx;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (clr_we)
        mem[cnt_q] <= '0;
      if (ld_we)
        mem[LD_ADDR] <= LD_DATA;
      if (d_we)
        mem[da] <= DWDATA;
    end
  end

  assign INSTR     = instr_q;
  assign DRDATA    = drdata_q;
  assign INIT_BUSY = busy_q;

endmodule

// File: doc/risc_toy_mem_responder.md
Name: risc_toy_mem_responder

Overview:
- Memory-side responder for the RISC-TOY core's instruction and data interfaces.
- Answers instruction fetches (IREQ/IADDR -> INSTR) and data accesses (DREQ/DRW/DADDR/DWDATA -> DRDATA) from one shared word array.
- Zero-clears the whole array after reset.
- Provides a loader write port so benches and boot logic can preload programs once the clear has finished.

Parameters:
- AW, 10, word-address bits decoded from IADDR/DADDR; upper address bits are ignored (aliasing).
- DEPTH, 1024, number of 32-bit words; must equal 2**AW.

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  synchronous active-high reset
- IREQ  input  1  instruction fetch request
- IADDR  input  30  instruction word address
- INSTR  output  32  fetched instruction, registered
- DREQ  input  1  data access request
- DRW  input  1  1 = write, 0 = read
- DADDR  input  30  data word address
- DWDATA  input  32  data write value
- DRDATA  output  32  data read value, registered
- LD_EN  input  1  loader write strobe
- LD_ADDR  input  AW  loader word address
- LD_DATA  input  32  loader write value
- INIT_BUSY  output  1  high while the post-reset clear is in progress

Behaviour:
- Clock and reset: one clock CLK; reset RST is synchronous and active-high.
- Reset (RST=1 at an edge): INSTR=0, DRDATA=0, INIT_BUSY=1, FSM=CLEAR, clear counter=0. Any write presented in that cycle is discarded. Reset mid-operation always restarts the clear from word 0.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each cycle writes 0 to mem[cnt] and increments cnt (AW bits).
  - When cnt==DEPTH-1 is written, the FSM moves to READY and INIT_BUSY drops on that same edge.
  - Total INIT_BUSY high time is DEPTH cycles after reset deasserts.
  - IREQ, DREQ and LD_EN are ignored; INSTR and DRDATA hold 0.
- READY, instruction port:
  - IREQ=1 at edge N: INSTR at N+1 = mem[IADDR[AW-1:0]].
  - IREQ=0: INSTR holds its previous value.
- READY, data port:
  - DREQ=1, DRW=0: DRDATA at N+1 = mem[DADDR[AW-1:0]].
  - DREQ=1, DRW=1: mem[DADDR[AW-1:0]] <= DWDATA at edge N; DRDATA holds.
  - DREQ=0: no access; DRDATA holds.
- READY, loader: LD_EN=1 writes mem[LD_ADDR] <= LD_DATA at edge N.
- Write collision: a data-port write and a loader write to the same address in the same cycle leave the DWDATA value stored. Writes to different addresses both commit.
- Read-during-write (write-first):
  - An instruction read in the same cycle as a write to the same index returns the new value, including the collision-resolved winner.
  - A data read cannot coincide with a data write. A data read coinciding with a loader write to the same index also returns LD_DATA.
- Read latency is exactly 1 cycle for both ports. There is no back-pressure: every request issued in READY completes.
- Address aliasing: IADDR/DADDR bits [29:AW] are ignored, so address k and k+DEPTH map to the same word.
- All outputs are driven only from registers; there are no combinational paths from inputs to outputs.

Test Plan:
- Clear timing: DEPTH=16, AW=4, RST high 2 cycles then low -> INIT_BUSY stays high exactly 16 cycles. A DREQ read of addr 5 issued during CLEAR leaves DRDATA=0. After READY, reads of all 16 words return 0.
- Load and fetch: LD_EN writes 0x1800_0005 to addr 3, then IREQ with IADDR=3 -> INSTR=0x1800_0005 one cycle later. With IREQ=0 next cycle -> INSTR holds 0x1800_0005.
- Data write/read: DREQ=1, DRW=1, DADDR=7, DWDATA=0xDEAD_BEEF, then DREQ=1, DRW=0, DADDR=7 -> DRDATA=0xDEAD_BEEF at the following edge. DRDATA is unchanged during the write cycle.
- Forwarding and collision: same cycle data write 0xAAAA_AAAA, loader write 0x5555_5555 and IREQ all at addr 9 -> INSTR=0xAAAA_AAAA next cycle and mem[9]=0xAAAA_AAAA.
- Aliasing: with AW=4, write 0x1234 to DADDR=0x13 -> a read of DADDR=0x3 returns 0x1234.
- Reset mid-operation: after loading addr 2=0xFFFF_FFFF, assert RST for 1 cycle during a DREQ write -> INSTR=DRDATA=0, INIT_BUSY=1 for DEPTH cycles, and addr 2 reads 0 afterward.
